// File: rtl/hwag_capture_multi.sv
// Multi-channel input capture: each pin is synchronised, glitch-filtered and
// edge-detected, and every selected edge latches the shared free-running timestamp.
module hwag_capture_multi #(
  parameter int CH = 2,
  parameter int FW = 4,
  parameter int TW = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [CH-1:0]    d,
  input  logic [CH*FW-1:0] flt_val,
  input  logic [2*CH-1:0]  mode,
  input  logic [CH-1:0]    ack,
  output logic [CH-1:0]    filtered,
  output logic [CH-1:0]    edge_p,
  output logic [TW-1:0]    tstamp,
  output logic [CH*TW-1:0] cap_ts,
  output logic [CH-1:0]    cap_valid,
  output logic [CH-1:0]    cap_ovf
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tstamp <= '0;
    end else if (ena) begin
      tstamp <= tstamp + 1'b1;
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic          s1;
    logic          s2;
    logic          filt;
    logic          filt_d;
    logic          pulse;
    logic          valid;
    logic          ovf;
    logic [FW-1:0] cnt;
    logic [TW-1:0] ts;
    logic [FW-1:0] limit;
    logic [1:0]    md;
    logic          det;

    assign limit = flt_val[i*FW +: FW];
    assign md    = mode[2*i +: 2];
    // det already carries ena, so a frozen channel can neither pulse nor capture
    assign det   = ena & ((filt & ~filt_d & md[0]) | (~filt & filt_d & md[1]));

    // The counter wraps when a lowered limit is already behind it
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        s1     <= 1'b0;
        s2     <= 1'b0;
        filt   <= 1'b0;
        filt_d <= 1'b0;
        cnt    <= '0;
      end else if (ena) begin
        s1     <= d[i];
        s2     <= s1;
        filt_d <= filt;
        if (s2 == filt) begin
          cnt <= '0;
        end else if (cnt == limit) begin
          filt <= s2;
          cnt  <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        pulse <= 1'b0;
      end else begin
        pulse <= det;
      end
    end

    // A capture coinciding with ack re-arms valid but acknowledges the old event
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        ts    <= '0;
        valid <= 1'b0;
        ovf   <= 1'b0;
      end else if (det) begin
        ts    <= tstamp;
        valid <= 1'b1;
        if (ack[i]) begin
          ovf <= 1'b0;
        end else if (valid) begin
          ovf <= 1'b1;
        end
      end else if (ack[i]) begin
        valid <= 1'b0;
        ovf   <= 1'b0;
      end
    end

    assign filtered[i]          = filt;
    assign edge_p[i]            = pulse & ena;
    assign cap_ts[i*TW +: TW]   = ts;
    assign cap_valid[i]         = valid;
    assign cap_ovf[i]           = ovf;
  end

endmodule

// File: tb/tb_hwag_capture_multi.sv
// Randomised and directed bench for hwag_capture_multi against a cycle model
// built from the pin-level rules: stability runs, edge selection and capture bookkeeping.
module tb_hwag_capture_multi;
  localparam int CH = 2;
  localparam int FW = 4;
  localparam int TW = 6;
  localparam int TS_MOD = 1 << TW;
  localparam int RUN_MOD = 1 << FW;

  logic             clk = 1'b0;
  logic             rst;
  logic             ena;
  logic [CH-1:0]    d;
  logic [CH*FW-1:0] flt_val;
  logic [2*CH-1:0]  mode;
  logic [CH-1:0]    ack;
  logic [CH-1:0]    filtered;
  logic [CH-1:0]    edge_p;
  logic [TW-1:0]    tstamp;
  logic [CH*TW-1:0] cap_ts;
  logic [CH-1:0]    cap_valid;
  logic [CH-1:0]    cap_ovf;

  int total = 0;
  int bad = 0;

  // Reference state: pin history, settled level, run length and capture record
  int m_ts;
  bit m_pin1[CH];
  bit m_pin2[CH];
  bit m_lvl[CH];
  bit m_prev[CH];
  int m_run[CH];
  bit m_pulse[CH];
  int m_cap[CH];
  bit m_valid[CH];
  bit m_ovf[CH];

  hwag_capture_multi #(.CH(CH), .FW(FW), .TW(TW)) dut (
    .clk(clk), .rst(rst), .ena(ena), .d(d), .flt_val(flt_val), .mode(mode),
    .ack(ack), .filtered(filtered), .edge_p(edge_p), .tstamp(tstamp),
    .cap_ts(cap_ts), .cap_valid(cap_valid), .cap_ovf(cap_ovf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void modelReset();
    m_ts = 0;
    for (int c = 0; c < CH; c++) begin
      m_pin1[c] = 0; m_pin2[c] = 0; m_lvl[c] = 0; m_prev[c] = 0;
      m_run[c] = 0; m_pulse[c] = 0; m_cap[c] = 0; m_valid[c] = 0; m_ovf[c] = 0;
    end
  endfunction

  function automatic void modelStep();
    for (int c = 0; c < CH; c++) begin
      int limit;
      int sel;
      bit fire;
      bit rose;
      bit fell;
      limit = int'((flt_val >> (c * FW)) & (RUN_MOD - 1));
      sel = int'((mode >> (2 * c)) & 2'b11);
      rose = m_lvl[c] && !m_prev[c];
      fell = !m_lvl[c] && m_prev[c];
      fire = ena && ((rose && (sel == 1 || sel == 3)) || (fell && (sel == 2 || sel == 3)));
      if (ena) begin
        m_prev[c] = m_lvl[c];
        if (m_pin2[c] == m_lvl[c]) m_run[c] = 0;
        else if (m_run[c] == limit) begin
          m_lvl[c] = m_pin2[c];
          m_run[c] = 0;
        end else m_run[c] = (m_run[c] + 1) % RUN_MOD;
        m_pin2[c] = m_pin1[c];
        m_pin1[c] = d[c];
      end
      m_pulse[c] = fire;
      if (fire) begin
        m_cap[c] = m_ts;
        if (ack[c]) m_ovf[c] = 0;
        else if (m_valid[c]) m_ovf[c] = 1;
        m_valid[c] = 1;
      end else if (ack[c]) begin
        m_valid[c] = 0;
        m_ovf[c] = 0;
      end
    end
    if (ena) m_ts = (m_ts + 1) % TS_MOD;
  endfunction

  task automatic checkAll();
    logic [63:0] e_f, e_p, e_v, e_o, e_ts;
    e_f = '0; e_p = '0; e_v = '0; e_o = '0; e_ts = '0;
    for (int c = 0; c < CH; c++) begin
      e_f[c] = m_lvl[c];
      e_p[c] = m_pulse[c] & ena;
      e_v[c] = m_valid[c];
      e_o[c] = m_ovf[c];
      e_ts[c*TW +: TW] = m_cap[c][TW-1:0];
    end
    checkOutput("filtered", 64'(filtered), e_f);
    checkOutput("edge_p", 64'(edge_p), e_p);
    checkOutput("tstamp", 64'(tstamp), 64'(m_ts));
    checkOutput("cap_ts", 64'(cap_ts), e_ts);
    checkOutput("cap_valid", 64'(cap_valid), e_v);
    checkOutput("cap_ovf", 64'(cap_ovf), e_o);
  endtask

  task automatic runCycle();
    @(posedge clk);
    if (rst) modelStep();
    #1;
    checkAll();
  endtask

  task automatic applyStimulus(input logic [CH-1:0] pins, input logic [CH-1:0] acks,
                               input logic enable, input int cycles);
    d = pins;
    ack = acks;
    ena = enable;
    for (int k = 0; k < cycles; k++) runCycle();
  endtask

  initial begin
    int n;
    int pulses;
    bit found;
    rst = 1'b0; ena = 1'b0; d = '0; ack = '0; flt_val = '0; mode = '0;
    modelReset();
    #12;
    checkAll();
    @(negedge clk);
    rst = 1'b1;

    // Rising edge latency with a 3-cycle stability count
    flt_val = {4'd3, 4'd3};
    mode = 4'b0001;
    applyStimulus(2'b00, 2'b00, 1'b1, 10);
    d = 2'b01;
    n = 0; found = 0;
    for (int k = 1; k <= 20 && !found; k++) begin
      runCycle();
      if (edge_p[0]) begin found = 1; n = k; end
    end
    checkOutput("rise_latency", 64'(n), 64'd7);
    checkOutput("rise_valid", 64'(cap_valid[0]), 64'd1);

    // Glitch rejection: 3-cycle pulse vanishes, 4-cycle pulse survives
    applyStimulus(2'b00, 2'b00, 1'b1, 12);
    applyStimulus(2'b00, 2'b01, 1'b1, 1);
    pulses = 0;
    applyStimulus(2'b01, 2'b00, 1'b1, 3);
    d = 2'b00;
    for (int k = 0; k < 15; k++) begin runCycle(); pulses += int'(edge_p[0]); end
    checkOutput("glitch3_edges", 64'(pulses), 64'd0);
    checkOutput("glitch3_valid", 64'(cap_valid[0]), 64'd0);
    pulses = 0;
    d = 2'b01;
    for (int k = 0; k < 4; k++) begin runCycle(); pulses += int'(edge_p[0]); end
    d = 2'b00;
    for (int k = 0; k < 15; k++) begin runCycle(); pulses += int'(edge_p[0]); end
    checkOutput("pulse4_edges", 64'(pulses), 64'd1);

    // Two edges without ack raise overflow; ack clears both flags
    flt_val = '0;
    mode = 4'b0011;
    applyStimulus(2'b00, 2'b01, 1'b1, 1);
    applyStimulus(2'b01, 2'b00, 1'b1, 20);
    applyStimulus(2'b00, 2'b00, 1'b1, 10);
    checkOutput("ovf_set", 64'(cap_ovf[0]), 64'd1);

    // Ack lands exactly on the capture edge of the next toggle
    applyStimulus(2'b01, 2'b00, 1'b1, 3);
    applyStimulus(2'b01, 2'b01, 1'b1, 1);
    checkOutput("ack_cap_valid", 64'(cap_valid[0]), 64'd1);
    checkOutput("ack_cap_ovf", 64'(cap_ovf[0]), 64'd0);
    applyStimulus(2'b01, 2'b01, 1'b1, 1);
    checkOutput("ack_clear", 64'({cap_valid[0], cap_ovf[0]}), 64'd0);

    // Freeze in the middle of a long filter count
    flt_val = {4'd5, 4'd5};
    applyStimulus(2'b00, 2'b00, 1'b1, 6);
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(2'b00, 2'b00, 1'b0, 1);
      pulses += int'(edge_p[0]);
    end
    checkOutput("freeze_edges", 64'(pulses), 64'd0);
    applyStimulus(2'b00, 2'b00, 1'b1, 12);

    // Simultaneous edges, channel 1 switched off
    flt_val = {4'd1, 4'd1};
    mode = 4'b0001;
    applyStimulus(2'b00, 2'b11, 1'b1, 1);
    applyStimulus(2'b11, 2'b00, 1'b1, 10);
    checkOutput("sim_valid", 64'(cap_valid), 64'b01);
    mode = 4'b0111;
    applyStimulus(2'b00, 2'b00, 1'b1, 10);

    // Randomised traffic across timestamp wraps and mode/limit changes
    for (int k = 0; k < 3000; k++) begin
      if (k % 150 == 0) begin
        flt_val = {4'($urandom_range(0, 6)), 4'($urandom_range(0, 6))};
        mode = 4'($urandom);
      end
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 5) == 0) d[c] = ~d[c];
        ack[c] = ($urandom_range(0, 7) == 0);
      end
      ena = ($urandom_range(0, 9) != 0);
      runCycle();
    end

    // Asynchronous reset lands between clock edges
    ena = 1'b1;
    @(posedge clk);
    #3;
    rst = 1'b0;
    modelReset();
    #1;
    checkAll();
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(2'b00, 2'b00, 1'b1, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
